// File: rtl/pwm_duty_sched_if.sv
// Command/duty bundle between steering logic and the duty scheduler.
interface pwm_duty_sched_if;
    logic               tgt_vld;
    logic signed [13:0] lft_tgt;
    logic signed [13:0] rht_tgt;
    logic               estop;
    logic signed [13:0] lft_duty;
    logic signed [13:0] rht_duty;
    logic               wrt_lft;
    logic               wrt_rht;
    logic               at_tgt_lft;
    logic               at_tgt_rht;

    // Command source side
    modport master (
        output tgt_vld, lft_tgt, rht_tgt, estop,
        input  lft_duty, rht_duty, wrt_lft, wrt_rht, at_tgt_lft, at_tgt_rht
    );

    // Scheduler side
    modport slave (
        input  tgt_vld, lft_tgt, rht_tgt, estop,
        output lft_duty, rht_duty, wrt_lft, wrt_rht, at_tgt_lft, at_tgt_rht
    );
endinterface

// File: rtl/pwm_duty_sched.sv
// Rate-limited duty sequencer for the left/right PWM channels, with a
// zero-duty dwell on direction reversal and a synchronous emergency stop.
module pwm_duty_sched #(
    parameter int unsigned PERIOD_BITS  = 13,
    parameter int unsigned STEP         = 256,
    parameter int unsigned DEAD_PERIODS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_duty_sched_if.slave  bus
);

    localparam int unsigned DW      = 14;
    localparam int unsigned NCH     = 2;
    localparam logic signed [DW:0] STEP_W = (DW+1)'(STEP);
    localparam logic [3:0]  DEAD_LD = 4'(DEAD_PERIODS);

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_RAMP = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
    logic                   tick;

    logic signed [DW-1:0] tgt_in  [NCH];
    logic signed [DW-1:0] step_v  [NCH];
    logic signed [DW-1:0] tgt_q   [NCH];
    logic signed [DW-1:0] tgt_d   [NCH];
    logic signed [DW-1:0] duty_q  [NCH];
    logic signed [DW-1:0] duty_d  [NCH];
    logic [1:0]           state_q [NCH];
    logic [1:0]           state_d [NCH];
    logic [3:0]           dwell_q [NCH];
    logic [3:0]           dwell_d [NCH];
    logic                 wrt_q   [NCH];
    logic                 wrt_d   [NCH];
    logic                 at_q    [NCH];
    logic                 at_d    [NCH];

    // One rate-limited step from d toward t
    function automatic logic signed [DW-1:0] ramp_next(
        input logic signed [DW-1:0] t,
        input logic signed [DW-1:0] d
    );
        logic signed [DW:0] ext_d;
        logic signed [DW:0] diff;
        logic signed [DW:0] mag;
        ext_d = {d[DW-1], d};
        diff  = {t[DW-1], t} - ext_d;
        mag   = diff[DW] ? -diff : diff;
        if (mag <= STEP_W) begin
            return t;
        end else if (diff[DW]) begin
            return DW'(ext_d - STEP_W);
        end else begin
            return DW'(ext_d + STEP_W);
        end
    endfunction

    // True when stepping d to n would cross or touch zero while heading to an opposite-sign target
    function automatic logic is_reversal(
        input logic signed [DW-1:0] t,
        input logic signed [DW-1:0] d,
        input logic signed [DW-1:0] n
    );
        logic d_pos, d_neg, t_pos, t_neg;
        d_neg = d[DW-1];
        d_pos = !d[DW-1] && (d != '0);
        t_neg = t[DW-1];
        t_pos = !t[DW-1] && (t != '0);
        return (d != '0) && ((n == '0) || (n[DW-1] != d[DW-1]))
               && ((t_pos && d_neg) || (t_neg && d_pos));
    endfunction

    // Most-negative code has no positive twin; fold it in by one
    function automatic logic signed [DW-1:0] clamp_tgt(input logic signed [DW-1:0] t);
        return (t == 14'h2000) ? 14'h2001 : t;
    endfunction

    assign tgt_in[0] = bus.lft_tgt;
    assign tgt_in[1] = bus.rht_tgt;
    assign tick      = &cnt_q;

    // Next-state: period counter, target capture, per-channel ramp FSM and strobes
    always_comb begin
        cnt_d = cnt_q + PERIOD_BITS'(1);
        for (int c = 0; c < int'(NCH); c++) begin
            tgt_d[c]   = tgt_q[c];
            duty_d[c]  = duty_q[c];
            state_d[c] = state_q[c];
            dwell_d[c] = dwell_q[c];
            wrt_d[c]   = 1'b0;
            step_v[c]  = ramp_next(tgt_q[c], duty_q[c]);

            if (bus.estop) begin
                tgt_d[c]   = '0;
                duty_d[c]  = '0;
                state_d[c] = ST_HOLD;
                dwell_d[c] = '0;
                wrt_d[c]   = (duty_q[c] != '0);
            end else begin
                if (tick) begin
                    case (state_q[c])
                        ST_HOLD, ST_RAMP: begin
                            if ((state_q[c] == ST_RAMP) || (duty_q[c] != tgt_q[c])) begin
                                if (is_reversal(tgt_q[c], duty_q[c], step_v[c])) begin
                                    duty_d[c]  = '0;
                                    state_d[c] = ST_DEAD;
                                    dwell_d[c] = DEAD_LD;
                                end else begin
                                    duty_d[c]  = step_v[c];
                                    state_d[c] = (step_v[c] == tgt_q[c]) ? ST_HOLD : ST_RAMP;
                                end
                            end
                        end
                        ST_DEAD: begin
                            dwell_d[c] = dwell_q[c] - 4'd1;
                            if (dwell_q[c] == 4'd1) begin
                                state_d[c] = ST_RAMP;
                            end
                        end
                        default: state_d[c] = ST_HOLD;
                    endcase
                    wrt_d[c] = (duty_d[c] != duty_q[c]);
                end
                // Capture after the tick decision so a same-cycle target waits a period
                if (bus.tgt_vld) begin
                    tgt_d[c] = clamp_tgt(tgt_in[c]);
                end
            end
            at_d[c] = (state_d[c] == ST_HOLD) && (duty_d[c] == tgt_d[c]);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int c = 0; c < int'(NCH); c++) begin
                tgt_q[c]   <= '0;
                duty_q[c]  <= '0;
                state_q[c] <= ST_HOLD;
                dwell_q[c] <= '0;
                wrt_q[c]   <= 1'b0;
                at_q[c]    <= 1'b1;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int c = 0; c < int'(NCH); c++) begin
                tgt_q[c]   <= tgt_d[c];
                duty_q[c]  <= duty_d[c];
                state_q[c] <= state_d[c];
                dwell_q[c] <= dwell_d[c];
                wrt_q[c]   <= wrt_d[c];
                at_q[c]    <= at_d[c];
            end
        end
    end

    assign bus.lft_duty   = duty_q[0];
    assign bus.rht_duty   = duty_q[1];
    assign bus.wrt_lft    = wrt_q[0];
    assign bus.wrt_rht    = wrt_q[1];
    assign bus.at_tgt_lft = at_q[0];
    assign bus.at_tgt_rht = at_q[1];

endmodule
